bcd_anode_scanner: RTL and testbench

- Drives the digit-select side of the multiplexed 4-digit 7-segment display; the per-digit BCD-to-cathode decoder sits downstream.
- Accepts a binary value (e.g. servo angle or position) with a load strobe.
- Converts the value to packed BCD sequentially using shift-add-3 (double dabble), one bit per cycle.
- Time-multiplexes the digits: drives the active-low anodes and presents the selected digit's 4-bit BCD code to the cathode decoder.

---
 rtl/bcd_anode_scanner.sv | 143 ++++++++++++++
 tb/tb_bcd_anode_scanner.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_anode_scanner.sv
// Binary-to-BCD converter (shift-add-3, one bit per clock) feeding a free-running
// multiplexed digit scanner with active-low anodes and optional leading-zero blanking.
module bcd_anode_scanner #(
   parameter int NUM_DIGITS  = 4,
   parameter int BIN_WIDTH   = 14,
   parameter int REFRESH_DIV = 50000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [BIN_WIDTH-1:0]  bin_value,
   input  logic                  blank_lz,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic [NUM_DIGITS-1:0] anode,
   output logic [3:0]            selected_digit_data
);
   localparam int          BCD_W   = 4 * NUM_DIGITS;
   localparam int          CNT_W   = $clog2(BIN_WIDTH + 1);
   localparam int          REF_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int          IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [63:0] MAX_VAL = 64'(10 ** NUM_DIGITS) - 64'd1;

   typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

   state_t                  state_q, state_d;
   logic [BIN_WIDTH-1:0]    shift_q, shift_d;
   logic [BCD_W-1:0]        bcd_q, bcd_d, bcd_adj;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    ovf_q, ovf_d;
   logic                    done_q, done_d;
   logic [BCD_W-1:0]        disp_q, disp_d;
   logic [REF_W-1:0]        ref_q, ref_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [NUM_DIGITS-1:0]   anode_q, anode_d;
   logic [3:0]              sel_q, sel_d;
   logic                    upper_nz;

   // Handshake: load is taken only on a cycle where busy is low; a load seen
   // while busy is high (SHIFT or LATCH) is dropped, never queued.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      disp_d  = disp_q;
      done_d  = 1'b0;
      bcd_adj = bcd_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
      case (state_q)
         IDLE: begin
            if (load) begin
               if (64'(bin_value) > MAX_VAL) begin
                  shift_d = BIN_WIDTH'(MAX_VAL);
                  ovf_d   = 1'b1;
               end else begin
                  shift_d = bin_value;
                  ovf_d   = 1'b0;
               end
               bcd_d   = '0;
               cnt_d   = CNT_W'(BIN_WIDTH);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            bcd_d   = {bcd_adj[BCD_W-2:0], shift_q[BIN_WIDTH-1]};
            shift_d = shift_q << 1;
            cnt_d   = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = LATCH;
            end
         end
         LATCH: begin
            disp_d  = bcd_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Scanner runs from the display register only, so a conversion never disturbs it.
   always_comb begin
      ref_d = ref_q + REF_W'(1);
      idx_d = idx_q;
      if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
         ref_d = '0;
         idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end
      upper_nz = 1'b0;
      for (int j = 0; j < NUM_DIGITS; j++) begin
         if (j >= int'(idx_q) && disp_q[4*j +: 4] != 4'd0) begin
            upper_nz = 1'b1;
         end
      end
      sel_d   = disp_q[4*int'(idx_q) +: 4];
      anode_d = ~(NUM_DIGITS'(1) << idx_q);
      if (blank_lz && idx_q != '0 && !upper_nz) begin
         anode_d = '1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
         disp_q  <= '0;
         ref_q   <= '0;
         idx_q   <= '0;
         anode_q <= '1;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
         disp_q  <= disp_d;
         ref_q   <= ref_d;
         idx_q   <= idx_d;
         anode_q <= anode_d;
         sel_q   <= sel_d;
      end
   end

   assign busy                = (state_q != IDLE);
   assign done                = done_q;
   assign overflow            = ovf_q;
   assign anode               = anode_q;
   assign selected_digit_data = sel_q;

endmodule

// File: tb/tb_bcd_anode_scanner.sv
// Bench for bcd_anode_scanner: decimal reference model tracked per clock, scenario tasks
// compare DUT outputs against it at every falling edge plus explicit digit/latency checks.
module tb_bcd_anode_scanner;
  localparam int ND = 4;
  localparam int BW = 14;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic [BW-1:0] bin_value = '0;
  logic          blank_lz = 1'b0;
  logic          busy, done, overflow;
  logic [ND-1:0] anode;
  logic [3:0]    selected_digit_data;

  int asserts = 0;
  int failures = 0;

  // reference model state: edges since reset, decimal display value, conversion timer
  int            m_edge = 0;
  int            m_t = 0;
  int            m_disp = 0;
  int            m_pend = 0;
  int            m_idx = 0;
  bit            m_busy = 1'b0;
  bit            m_done = 1'b0;
  bit            m_ovf = 1'b0;
  logic [ND-1:0] m_anode = '1;
  logic [3:0]    m_data = '0;

  logic [ND+6:0] dut_vec;
  logic [ND+6:0] exp_vec;
  assign dut_vec = {busy, done, overflow, anode, selected_digit_data};
  assign exp_vec = {m_busy, m_done, m_ovf, m_anode, m_data};

  bcd_anode_scanner #(
    .NUM_DIGITS (ND),
    .BIN_WIDTH  (BW),
    .REFRESH_DIV(RD)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .load               (load),
    .bin_value          (bin_value),
    .blank_lz           (blank_lz),
    .busy               (busy),
    .done               (done),
    .overflow           (overflow),
    .anode              (anode),
    .selected_digit_data(selected_digit_data)
  );

  always #5 clk = ~clk;

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_edge = 0; m_t = 0; m_disp = 0; m_pend = 0;
      m_busy = 1'b0; m_done = 1'b0; m_ovf = 1'b0;
      m_anode = '1; m_data = '0;
    end else begin
      m_idx = (m_edge / RD) % ND;
      m_data = 4'((m_disp / pow10(m_idx)) % 10);
      m_anode = ~(4'b0001 << m_idx);
      if (blank_lz && m_idx != 0 && m_disp < pow10(m_idx)) m_anode = '1;
      m_edge++;
      m_done = 1'b0;
      if (m_busy) begin
        m_t++;
        if (m_t == BW + 1) begin
          m_disp = m_pend; m_done = 1'b1; m_busy = 1'b0;
        end
      end else if (load) begin
        m_busy = 1'b1;
        m_t = 0;
        m_ovf = (int'(bin_value) > pow10(ND) - 1);
        m_pend = m_ovf ? pow10(ND) - 1 : int'(bin_value);
      end
    end
  end

  // Drives one load and runs 32 cycles; returns digits seen over a full scan after done.
  task automatic do_conversion(input int v, input bit blz, input string tag,
                               output logic [15:0] seen, output int done_at, output int lit);
    seen = '0; done_at = -1; lit = 0;
    load = 1'b1; bin_value = BW'(v); blank_lz = blz;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (k == 0) load = 1'b0;
      asserts++;
      if (dut_vec !== exp_vec) begin
        failures++;
        $display("FAIL %s_cycle k=%0d: got %b expected %b", tag, k, dut_vec, exp_vec);
      end
      if (done === 1'b1 && done_at < 0) done_at = k;
      if (k >= 16) begin
        for (int p = 0; p < ND; p++) begin
          if (anode === ~(4'b0001 << p)) begin
            seen[4*p +: 4] = selected_digit_data;
            lit++;
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; blank_lz = 1'b0;
    repeat (3) begin
      @(negedge clk);
      asserts++;
      if (dut_vec !== 11'b000_1111_0000) begin
        failures++;
        $display("FAIL reset_state: got %b expected %b", dut_vec, 11'b000_1111_0000);
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      asserts++;
      if (anode !== ~(4'b0001 << ((k / RD) % ND)) || selected_digit_data !== 4'd0) begin
        failures++;
        $display("FAIL reset_scan k=%0d: got anode %b data %0d expected anode %b data 0",
                 k, anode, selected_digit_data, ~(4'b0001 << ((k / RD) % ND)));
      end
      asserts++;
      if (dut_vec !== exp_vec) begin
        failures++;
        $display("FAIL reset_model k=%0d: got %b expected %b", k, dut_vec, exp_vec);
      end
    end
  endtask

  task automatic test_load_basic();
    logic [15:0] seen; int done_at; int lit;
    do_conversion(1234, 1'b0, "basic", seen, done_at, lit);
    asserts++;
    if (done_at != 15) begin
      failures++; $display("FAIL basic_latency: got %0d expected 15", done_at);
    end
    asserts++;
    if (seen !== 16'h1234) begin
      failures++; $display("FAIL basic_digits: got %h expected 1234", seen);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] seen; int done_at; int lit;
    do_conversion(16383, 1'b0, "ovf", seen, done_at, lit);
    asserts++;
    if (seen !== 16'h9999 || overflow !== 1'b1) begin
      failures++; $display("FAIL ovf_clamp: got %h ovf %b expected 9999 ovf 1", seen, overflow);
    end
    do_conversion(7, 1'b1, "small", seen, done_at, lit);
    asserts++;
    if (seen !== 16'h0007 || overflow !== 1'b0 || lit != 4) begin
      failures++;
      $display("FAIL small_blank: got %h ovf %b lit %0d expected 0007 ovf 0 lit 4", seen, overflow, lit);
    end
  endtask

  task automatic test_zero_blank();
    logic [15:0] seen; int done_at; int lit;
    do_conversion(0, 1'b1, "zero", seen, done_at, lit);
    asserts++;
    if (seen !== 16'h0000 || lit != 4 || done_at != 15) begin
      failures++;
      $display("FAIL zero_blank: got %h lit %0d done_at %0d expected 0000 lit 4 done_at 15", seen, lit, done_at);
    end
  endtask

  task automatic test_back_to_back();
    int dones[$];
    int d0, d1;
    logic [15:0] seen = '0;
    load = 1'b1; bin_value = 14'd42; blank_lz = 1'b0;
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      asserts++;
      if (dut_vec !== exp_vec) begin
        failures++; $display("FAIL b2b_cycle k=%0d: got %b expected %b", k, dut_vec, exp_vec);
      end
      if (done === 1'b1) dones.push_back(k);
      load = 1'b0;
      if (k == 4 || k == 15) begin
        load = 1'b1; bin_value = 14'd999;
      end
      if (k >= 32) begin
        for (int p = 0; p < ND; p++)
          if (anode === ~(4'b0001 << p)) seen[4*p +: 4] = selected_digit_data;
      end
    end
    d0 = (dones.size() > 0) ? dones[0] : -1;
    d1 = (dones.size() > 1) ? dones[1] : -1;
    asserts++;
    if (dones.size() != 2 || d0 != 15 || d1 != 31) begin
      failures++;
      $display("FAIL b2b_done_times: got %0d pulses at %0d,%0d expected 2 at 15,31", dones.size(), d0, d1);
    end
    asserts++;
    if (seen !== 16'h0999) begin
      failures++; $display("FAIL b2b_digits: got %h expected 0999", seen);
    end
  endtask

  task automatic test_reset_abort();
    int n_done = 0;
    logic [15:0] seen; int done_at; int lit;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    load = 1'b1; bin_value = 14'd5678; blank_lz = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      asserts++;
      if (dut_vec !== exp_vec) begin
        failures++; $display("FAIL abort_cycle k=%0d: got %b expected %b", k, dut_vec, exp_vec);
      end
      if (done === 1'b1) n_done++;
      if (k == 7) begin
        asserts++;
        if (busy !== 1'b0) begin
          failures++; $display("FAIL abort_busy: got %b expected 0", busy);
        end
      end
      load = 1'b0;
      rst = (k == 6);
    end
    asserts++;
    if (n_done != 0) begin
      failures++; $display("FAIL abort_no_done: got %0d pulses expected 0", n_done);
    end
    do_conversion(5678, 1'b0, "reload", seen, done_at, lit);
    asserts++;
    if (seen !== 16'h5678 || done_at != 15) begin
      failures++; $display("FAIL abort_reload: got %h done_at %0d expected 5678 done_at 15", seen, done_at);
    end
  endtask

  task automatic test_random();
    logic [15:0] seen; int done_at; int lit;
    int v, gap, clamped;
    bit blz;
    for (int it = 0; it < 10; it++) begin
      gap = $urandom_range(0, 5);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        asserts++;
        if (dut_vec !== exp_vec) begin
          failures++; $display("FAIL rand_gap it=%0d: got %b expected %b", it, dut_vec, exp_vec);
        end
      end
      v = $urandom_range(0, 16383);
      blz = 1'($urandom_range(0, 1));
      clamped = (v > 9999) ? 9999 : v;
      do_conversion(v, blz, "rand", seen, done_at, lit);
      asserts++;
      if (seen !== to_bcd(clamped) || done_at != 15 || overflow !== (v > 9999)) begin
        failures++;
        $display("FAIL rand_result v=%0d: got %h done_at %0d ovf %b expected %h done_at 15 ovf %b",
                 v, seen, done_at, overflow, to_bcd(clamped), (v > 9999));
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_overflow();
    test_zero_blank();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
